// File: rtl/temp_sense_counter.sv
// temp_sense_counter: per-channel ring-oscillator edge counter over a programmable gate window, with latched results, readout mux, serial chain and irq.
// Latency: edge-to-count SYNC_STAGES+1 cycles; done is visible N+3 cycles after start is driven (N = max(win_len,1)), then every N+2 cycles in continuous mode.
// Backpressure: none; start is ignored while busy, and the serial chain advances only on shift_en (a LATCH load takes priority over a shift).
module temp_sense_counter #(
    parameter int  NUM_CH      = 4,
    parameter int  CNT_W       = 16,
    parameter int  WIN_W       = 20,
    parameter int  SYNC_STAGES = 2,
    localparam int RD_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic [NUM_CH-1:0]       vco_in,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    start,
    input  logic                    continuous,
    input  logic [WIN_W-1:0]        win_len,
    output logic                    busy,
    output logic                    done,
    output logic [NUM_CH-1:0]       ovf,
    input  logic [RD_W-1:0]         rd_sel,
    output logic [CNT_W-1:0]        rd_data,
    input  logic                    shift_en,
    output logic                    sr_out,
    output logic                    irq,
    input  logic                    irq_clr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_COUNT = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    logic [NUM_CH-1:0][SYNC_STAGES-1:0] r_sync;
    logic [NUM_CH-1:0]                  r_prev;
    logic [NUM_CH-1:0]                  w_edge;

    state_t                             r_state;
    logic [WIN_W-1:0]                   r_wcnt;
    logic [NUM_CH-1:0][CNT_W-1:0]       r_live;
    logic [NUM_CH-1:0]                  r_live_ovf;
    logic [NUM_CH-1:0][CNT_W-1:0]       r_res;
    logic [NUM_CH-1:0]                  r_ovf;
    logic                               r_busy;
    logic                               r_done;
    logic                               r_irq;

    logic [NUM_CH*CNT_W-1:0]            r_sr;
    logic [NUM_CH*CNT_W-1:0]            w_sr_load;
    logic [CNT_W-1:0]                   w_rd_data;

    // Bring each asynchronous oscillator into the clock domain and keep one older sample for edge detection.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], vco_in[i]};
                r_prev[i] <= r_sync[i][SYNC_STAGES-1];
            end
        end
    end

    // Rising edge seen on the synchronised oscillator output.
    always_comb begin
        w_edge = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_edge[i] = r_sync[i][SYNC_STAGES-1] & ~r_prev[i];
        end
    end

    // Measurement sequencer: arm, gate the live counters for N cycles, latch results, optionally rearm.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state    <= S_IDLE;
            r_wcnt     <= '0;
            r_live     <= '0;
            r_live_ovf <= '0;
            r_res      <= '0;
            r_ovf      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_ARM;
                        r_busy  <= 1'b1;
                    end
                end
                S_ARM: begin
                    // A zero window would never terminate the down-count, so it runs as one cycle.
                    r_wcnt     <= (win_len == '0) ? WIN_W'(1) : win_len;
                    r_live     <= '0;
                    r_live_ovf <= '0;
                    r_state    <= S_COUNT;
                end
                S_COUNT: begin
                    r_wcnt <= r_wcnt - WIN_W'(1);
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (ch_en[i] && w_edge[i]) begin
                            // Saturate: an edge arriving at all-ones is recorded only as overflow.
                            if (r_live[i] == {CNT_W{1'b1}}) begin
                                r_live_ovf[i] <= 1'b1;
                            end else begin
                                r_live[i] <= r_live[i] + CNT_W'(1);
                            end
                        end
                    end
                    if (r_wcnt == WIN_W'(1)) begin
                        r_state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    r_res  <= r_live;
                    r_ovf  <= r_live_ovf;
                    r_done <= 1'b1;
                    if (continuous) begin
                        r_state <= S_ARM;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Serial image of the window's counts: channel 0 occupies the top bits, each count MSB-first.
    always_comb begin
        w_sr_load = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_sr_load[(NUM_CH-1-i)*CNT_W +: CNT_W] = r_live[i];
        end
    end

    // Shift chain: loaded in LATCH (wins over shift_en), otherwise shifts left with zero fill.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_sr <= '0;
        end else if (r_state == S_LATCH) begin
            r_sr <= w_sr_load;
        end else if (shift_en) begin
            r_sr <= {r_sr[NUM_CH*CNT_W-2:0], 1'b0};
        end
    end

    // Level interrupt: set by the done pulse, which beats a simultaneous clear.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_irq <= 1'b0;
        end else if (r_done) begin
            r_irq <= 1'b1;
        end else if (irq_clr) begin
            r_irq <= 1'b0;
        end
    end

    // Parallel readout mux over the latched results; out-of-range selects read zero.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_sel == RD_W'(i)) begin
                w_rd_data = r_res[i];
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign ovf     = r_ovf;
    assign rd_data = w_rd_data;
    assign sr_out  = r_sr[NUM_CH*CNT_W-1];
    assign irq     = r_irq;

endmodule

// File: tb/tb_temp_sense_counter.sv
// tb_temp_sense_counter: directed bench driving a 16-bit and a 4-bit counter instance with the same stimulus.
// Latency: a window-level model predicts every output each cycle; directed steps pin literal timings and counts.
// Backpressure: none; all waits are bounded and an expired bound shows up as a failed check.
module tb_temp_sense_counter;

    localparam int NCH = 4;
    localparam int S   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  vco = '0;
    logic [3:0]  ch_en = '0;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic [19:0] win_len = '0;
    logic [1:0]  rd_sel = '0;
    logic        shift_en = 1'b0;
    logic        irq_clr = 1'b0;

    logic        busy16, done16, sr16, irq16;
    logic [3:0]  ovf16;
    logic [15:0] rd16;
    logic        busy4, done4, sr4, irq4;
    logic [3:0]  ovf4;
    logic [3:0]  rd4;

    always #5 clk = ~clk;

    temp_sense_counter #(.NUM_CH(4), .CNT_W(16), .WIN_W(20), .SYNC_STAGES(2)) u_dut16 (
        .wb_clk_i(clk), .wb_rst_i(rst), .vco_in(vco), .ch_en(ch_en), .start(start),
        .continuous(cont), .win_len(win_len), .busy(busy16), .done(done16), .ovf(ovf16),
        .rd_sel(rd_sel), .rd_data(rd16), .shift_en(shift_en), .sr_out(sr16),
        .irq(irq16), .irq_clr(irq_clr)
    );

    temp_sense_counter #(.NUM_CH(4), .CNT_W(4), .WIN_W(20), .SYNC_STAGES(2)) u_dut4 (
        .wb_clk_i(clk), .wb_rst_i(rst), .vco_in(vco), .ch_en(ch_en), .start(start),
        .continuous(cont), .win_len(win_len), .busy(busy4), .done(done4), .ovf(ovf4),
        .rd_sel(rd_sel), .rd_data(rd4), .shift_en(shift_en), .sr_out(sr4),
        .irq(irq4), .irq_clr(irq_clr)
    );

    int errs = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Oscillator generators: per-channel period in clock cycles, 0 = stopped low.
    int per[NCH];
    int ph[NCH];
    initial begin
        for (int i = 0; i < NCH; i++) begin
            per[i] = 0;
            ph[i]  = 0;
        end
    end
    always @(negedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (per[i] == 0) begin
                vco[i] = 1'b0;
            end else begin
                ph[i]  = (ph[i] + 1) % per[i];
                vco[i] = (ph[i] < per[i] / 2);
            end
        end
    end

    // Window-level model. Edge numbers: cyc is the index of the latest rising clock edge.
    // A measurement whose start is sampled at edge s captures N at edge s+1, counts rises first
    // sampled S edges before each of edges s+2..s+1+N, and publishes results at edge s+2+N.
    int        cyc = 0;
    bit        m_active = 1'b0;
    int        m_s = 0;
    int        m_N = 0;
    int        raw[NCH];
    bit        rise[NCH][64];
    logic [3:0] pv = '0;
    int        m_res16[NCH];
    int        m_res4[NCH];
    logic [3:0]  m_ovf16 = '0;
    logic [3:0]  m_ovf4 = '0;
    logic [63:0] m_sr16 = '0;
    logic [15:0] m_sr4 = '0;
    bit        m_done = 1'b0;
    bit        m_irq = 1'b0;

    initial begin
        for (int i = 0; i < NCH; i++) begin
            raw[i] = 0; m_res16[i] = 0; m_res4[i] = 0;
            for (int j = 0; j < 64; j++) rise[i][j] = 1'b0;
        end
    end

    always @(posedge clk) begin : model
        bit latch;
        bit was_active;
        bit nirq;
        cyc++;
        if (rst) begin
            m_active = 1'b0; m_done = 1'b0; m_irq = 1'b0;
            m_ovf16 = '0; m_ovf4 = '0; m_sr16 = '0; m_sr4 = '0; pv = '0;
            for (int i = 0; i < NCH; i++) begin
                raw[i] = 0; m_res16[i] = 0; m_res4[i] = 0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) rise[i][cyc % 64] = vco[i] && !pv[i];
            pv = vco;
            nirq = m_done ? 1'b1 : (irq_clr ? 1'b0 : m_irq);
            latch = 1'b0;
            was_active = m_active;
            if (m_active) begin
                if (cyc == m_s + 1) begin
                    m_N = (win_len == 0) ? 1 : int'(win_len);
                    for (int i = 0; i < NCH; i++) raw[i] = 0;
                end else if (cyc >= m_s + 2 && cyc <= m_s + 1 + m_N) begin
                    for (int i = 0; i < NCH; i++)
                        if (ch_en[i] && rise[i][(cyc - S) % 64]) raw[i]++;
                end else if (cyc == m_s + 2 + m_N) begin
                    latch = 1'b1;
                end
            end
            m_done = latch;
            if (latch) begin
                m_sr16 = '0; m_sr4 = '0;
                for (int i = 0; i < NCH; i++) begin
                    m_res16[i] = (raw[i] > 65535) ? 65535 : raw[i];
                    m_ovf16[i] = (raw[i] > 65535);
                    m_res4[i]  = (raw[i] > 15) ? 15 : raw[i];
                    m_ovf4[i]  = (raw[i] > 15);
                    m_sr16 = (m_sr16 << 16) | 64'(m_res16[i]);
                    m_sr4  = (m_sr4 << 4) | 16'(m_res4[i]);
                end
                if (cont) m_s = cyc;
                else m_active = 1'b0;
            end else if (shift_en) begin
                m_sr16 = m_sr16 << 1;
                m_sr4  = m_sr4 << 1;
            end
            if (!was_active && start) begin
                m_active = 1'b1;
                m_s = cyc;
                m_N = 1 << 30;
            end
            m_irq = nirq;
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            #1;
            chk("cyc_busy16", busy16, m_active);
            chk("cyc_done16", done16, m_done);
            chk("cyc_irq16", irq16, m_irq);
            chk("cyc_ovf16", ovf16, m_ovf16);
            chk("cyc_rd16", rd16, 64'(m_res16[rd_sel]));
            chk("cyc_sr16", sr16, m_sr16[63]);
            chk("cyc_busy4", busy4, m_active);
            chk("cyc_done4", done4, m_done);
            chk("cyc_irq4", irq4, m_irq);
            chk("cyc_ovf4", ovf4, m_ovf4);
            chk("cyc_rd4", rd4, 64'(m_res4[rd_sel]));
            chk("cyc_sr4", sr4, m_sr4[15]);
        end
    end

    int rd_v16[NCH];
    int rd_v4[NCH];

    task automatic read_all();
        for (int i = 0; i < NCH; i++) begin
            @(negedge clk);
            rd_sel = 2'(i);
            #2;
            rd_v16[i] = int'(rd16);
            rd_v4[i]  = int'(rd4);
        end
    endtask

    // Pulse start for one cycle; k is the edge index current when start is driven high.
    task automatic start_pulse(output int k);
        @(negedge clk);
        k = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns the edge index at which done is first seen, or -1 when the bound expires.
    task automatic wait_done(input int bound, output int at);
        bit found;
        found = 1'b0;
        at = -1;
        for (int i = 0; i < bound && !found; i++) begin
            @(negedge clk);
            if (done16 === 1'b1) begin
                at = cyc;
                found = 1'b1;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int k, k2, t, t1, t2, t3, t4, t5;
        logic [63:0] got16;
        logic [15:0] got4;

        // Reset held over several edges with inputs toggling.
        per[0] = 4;
        repeat (3) begin
            @(negedge clk);
            start = ~start; shift_en = ~shift_en; irq_clr = ~irq_clr; ch_en = ~ch_en; cont = ~cont;
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0; shift_en = 1'b0; irq_clr = 1'b0; ch_en = '0; cont = 1'b0;
        chk_on = 1'b1;
        chk("rst_busy", busy16, 0);
        chk("rst_done", done16, 0);
        chk("rst_irq", irq16, 0);
        chk("rst_ovf", ovf16, 0);
        chk("rst_sr", sr16, 0);
        read_all();
        for (int i = 0; i < NCH; i++) chk("rst_rd", rd_v16[i], 0);

        // One-shot, channel 0 only, period 8 over 800 cycles.
        per[0] = 8; per[1] = 10; per[2] = 0; per[3] = 6;
        ch_en = 4'b0001; win_len = 20'd800;
        start_pulse(k);
        wait_done(900, t);
        chk("oneshot_done_latency", t - k, 803);
        chk("oneshot_busy_at_done", busy16, 0);
        @(negedge clk);
        chk("oneshot_irq", irq16, 1);
        read_all();
        chk("oneshot_cnt0_range", (rd_v16[0] >= 99 && rd_v16[0] <= 101), 1);
        for (int i = 1; i < NCH; i++) chk("oneshot_cnt_other", rd_v16[i], 0);
        chk("oneshot_ovf16", ovf16, 4'b0000);
        chk("oneshot_cnt0_w4", rd_v4[0], 15);
        chk("oneshot_ovf4", ovf4, 4'b0001);

        // Saturation: period 4 over 200 cycles gives 50 edges.
        per[0] = 4;
        win_len = 20'd200;
        start_pulse(k);
        wait_done(300, t);
        chk("sat_done_latency", t - k, 203);
        read_all();
        chk("sat_cnt0_w16", rd_v16[0], 50);
        chk("sat_cnt0_w4", rd_v4[0], 15);
        chk("sat_ovf4", ovf4, 4'b0001);
        chk("sat_ovf16", ovf16, 4'b0000);
        chk("sat_cnt1_w4", rd_v4[1], 0);

        // Serial readout: periods 8,10,off,6 over 240 cycles -> 30,24,0,40.
        per[0] = 8;
        ch_en = 4'b1111; win_len = 20'd240;
        start_pulse(k);
        wait_done(300, t);
        chk("ser_done_latency", t - k, 243);
        read_all();
        chk("ser_cnt0", rd_v16[0], 30);
        chk("ser_cnt1", rd_v16[1], 24);
        chk("ser_cnt2", rd_v16[2], 0);
        chk("ser_cnt3", rd_v16[3], 40);
        got16 = '0; got4 = '0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            got16 = {got16[62:0], sr16};
            if (i < 16) got4 = {got4[14:0], sr4};
            shift_en = 1'b1;
        end
        chk("ser_stream16", got16, 64'h001E_0018_0000_0028);
        chk("ser_stream4", got4, 16'hFF0F);
        repeat (4) @(negedge clk);
        chk("ser_zero_fill", sr16, 0);
        shift_en = 1'b0;

        // Continuous mode: done every N+2 cycles, one more after continuous drops.
        win_len = 20'd50; cont = 1'b1;
        start_pulse(k);
        wait_done(100, t1);
        chk("cont_first_latency", t1 - k, 53);
        wait_done(100, t2);
        chk("cont_period_a", t2 - t1, 52);
        wait_done(100, t3);
        chk("cont_period_b", t3 - t2, 52);
        cont = 1'b0;
        wait_done(100, t4);
        chk("cont_last_period", t4 - t3, 52);
        wait_done(150, t5);
        chk("cont_stopped", t5, -1);
        chk("cont_idle_busy", busy16, 0);

        // win_len 0 runs as a one-cycle window.
        win_len = 20'd0;
        start_pulse(k);
        wait_done(20, t);
        chk("win0_done_latency", t - k, 4);

        // start during COUNT is ignored.
        win_len = 20'd100;
        start_pulse(k);
        repeat (20) @(negedge clk);
        start_pulse(k2);
        wait_done(150, t);
        chk("restart_ignored_latency", t - k, 103);
        wait_done(150, t2);
        chk("restart_ignored_no_done", t2, -1);

        // Reset in the middle of a window discards it.
        start_pulse(k);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_done(150, t);
        chk("midrst_no_done", t, -1);
        chk("midrst_busy", busy16, 0);
        read_all();
        for (int i = 0; i < NCH; i++) chk("midrst_rd", rd_v16[i], 0);

        // irq_clr coinciding with done leaves irq set; a later clear drops it.
        win_len = 20'd5;
        start_pulse(k);
        wait_done(20, t);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        chk("irq_set_wins", irq16, 1);
        @(negedge clk);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        chk("irq_cleared", irq16, 0);

        repeat (3) @(negedge clk);
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/temp_sense_counter.md
# temp_sense_counter

Parametrised multi-channel digital back end for the ring-oscillator temperature/voltage sensors in the user project area. Counts rising edges from `NUM_CH` asynchronous oscillator outputs over a programmable gate window on `wb_clk_i`, then latches per-channel counts with overflow flags. Results are readable in parallel (channel-select mux) and serially through a shift chain on `sr_out`. Supports one-shot and back-to-back continuous measurement with a done interrupt, generalising the single-channel counter/shift-register sensor block.

## Interface
- `NUM_CH`, 4: oscillator channels, 1..8
- `CNT_W`, 16: per-channel count width, saturating
- `WIN_W`, 20: window-length register width
- `SYNC_STAGES`, 2: synchroniser flops per channel, ≥2

- `wb_clk_i` in 1: sole clock
- `wb_rst_i` in 1: synchronous, active-high reset
- `vco_in` in NUM_CH: raw oscillator outputs, asynchronous; frequency must be < f(wb_clk_i)/4
- `ch_en` in NUM_CH: channel enable, sampled every COUNT cycle
- `start` in 1: begins a measurement when in IDLE
- `continuous` in 1: sampled in LATCH; 1 = rearm immediately
- `win_len` in WIN_W: gate length in cycles, captured in ARM; 0 treated as 1
- `busy` out 1: high in ARM/COUNT/LATCH
- `done` out 1: one-cycle pulse, results valid
- `ovf` out NUM_CH: per-channel saturation flag of last window
- `rd_sel` in clog2(NUM_CH) (min 1): parallel readout channel select
- `rd_data` out CNT_W: latched count of channel `rd_sel`, combinational mux
- `shift_en` in 1: shift serial chain one bit per cycle
- `sr_out` out 1: MSB of serial chain
- `irq` out 1: level interrupt, set by `done`
- `irq_clr` in 1: clears `irq`

## Operation
- Per channel: `SYNC_STAGES`-flop synchroniser, one previous-value flop; rising edge = sync & ~prev.
- FSM: IDLE -> ARM on `start`; ARM (1 cycle: clear live counters and overflow, load window counter with max(win_len,1)) -> COUNT; COUNT decrements window counter each cycle, -> LATCH when it reaches 1; LATCH (1 cycle: copy live counts/overflow to result regs, load serial chain) -> ARM if `continuous`, else IDLE.
- During COUNT, an enabled channel with a detected edge increments its live counter; at all-ones it holds and sets its live overflow bit.
- `start` outside IDLE ignored; `continuous` deasserted mid-window ends after current window.
- Serial chain: NUM_CH*CNT_W bits, loaded as {count[0], count[1], …, count[NUM_CH-1]}, each MSB-first; `shift_en` shifts left, zero-fill. Load in LATCH overrides a simultaneous `shift_en`.
- `irq`: set when `done` asserts, cleared by `irq_clr`; simultaneous set and clear -> set wins.
- Reset: FSM IDLE; all counters, result regs, serial chain, synchronisers, `busy`, `done`, `ovf`, `irq`, `sr_out` = 0; `rd_data` = 0. Reset mid-measurement discards it, no `done`.

## Timing
- `start` high at edge k: ARM in cycle k+1, COUNT cycles k+2 … k+1+N (N = max(win_len,1)), LATCH k+2+N, `done`=1 and results visible in cycle k+3+N; `busy` low in that cycle only if not continuous.
- Continuous: consecutive `done` pulses every N+2 cycles; ARM fills the gap (edges there not counted).
- Edge-to-count latency: SYNC_STAGES+1 cycles; edges landing in ARM/LATCH are lost.
- Result regs, `ovf`, `rd_data` stable from `done` until next LATCH.

## Test plan
- Reset: assert `wb_rst_i` 2 cycles with toggling inputs -> all outputs 0, `busy`=0.
- One-shot: vco_in[0] period 8 clk, win_len=800, ch_en=4'b0001 -> `done` 803 cycles after start edge, count0 = 100±1, counts1..3 = 0, ovf=0, irq=1.
- Saturation: CNT_W=4, vco period 4 clk, win_len=200 -> count=15, ovf[0]=1; others 0.
- Continuous: continuous=1, win_len=50 -> `done` every 52 cycles; drop continuous -> one more `done`, then IDLE.
- Serial readout: counts {0xA5A5,0x0001,0,0xFFFF} -> 64 `shift_en` cycles give 0xA5A5 MSB first, then 0x0001, 0x0000, 0xFFFF; then zeros.
- Corner: win_len=0 -> N=1 window; `start` during COUNT ignored; reset during COUNT -> no `done`, counts 0; irq_clr with done same cycle -> irq=1.
